layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Multi-layer, multi-channel control sequencer for the CNN accelerator. It supersedes the single-layer control FSM. It walks `cfg_n_layer` layers, and for each layer it:
- computes per-layer DMA addresses;
- issues one DMA request;
- starts a masked set of convolution channels;
- frames the inbound stream with valid/sop/eop;
- collects DMA and per-channel completion.

It adds abort, a progress watchdog and error reporting, and sits between the CPU config registers, the AXI DMA wrapper and the convolution array.

## Interface
Parameters:
- `ADDR_W`, 32, DMA address width (byte addresses).
- `LEN_W`, 16, width of word-count fields.
- `N_CH`, 4, number of convolution channels.
- `MAX_LAYERS`, 8, maximum layers per run; `LW = $clog2(MAX_LAYERS+1)`.
- `TO_W`, 20, watchdog counter width.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Asynchronous, active-high.
- `cfg_start`  in  1  one-cycle start pulse.
- `cfg_abort`  in  1  one-cycle abort pulse.
- `cfg_n_layer`  in  LW  number of layers.
- `cfg_rd_base`  in  ADDR_W  layer-0 input base address.
- `cfg_wr_base`  in  ADDR_W  layer-0 output base address.
- `cfg_in_len`  in  LEN_W  input words per layer.
- `cfg_out_len`  in  LEN_W  output words per layer.
- `cfg_ch_mask`  in  N_CH  channels enabled.
- `dma_go`  out  1  DMA request pulse.
- `dma_rd_addr`  out  ADDR_W  DMA read address.
- `dma_wr_addr`  out  ADDR_W  DMA write address.
- `dma_len`  out  LEN_W  DMA transfer length in words.
- `dma_done`  in  1  DMA completion pulse.
- `s_tvalid`  in  1  inbound stream valid.
- `s_tready`  out  1  inbound stream ready.
- `conv_start`  out  N_CH  per-channel start pulse.
- `conv_done`  in  N_CH  per-channel done pulse.
- `valid_in`  out  1  stream word valid to convolution.
- `sop`  out  1  start of packet.
- `eop`  out  1  end of packet.
- `busy`  out  1  sequencer active.
- `cur_layer`  out  LW  index of current layer.
- `irq_done`  out  1  run-complete pulse.
- `irq_err`  out  1  error pulse.
- `err_code`  out  2  error cause: 0 none, 1 bad config, 2 timeout, 3 abort.

## Operation
- All cfg inputs are latched on an accepted `cfg_start` in IDLE. `cfg_start` is ignored when `busy`=1.
- States and transitions:
  - IDLE: on `cfg_start`, go to CHECK.
  - CHECK: go to ERR (code 1) if `n_layer`==0, `n_layer`>`MAX_LAYERS`, `in_len`==0 or `ch_mask`==0. Otherwise layer:=0, addresses := bases, go to ISSUE.
  - ISSUE: `dma_go`=1 and `conv_start`=`ch_mask` for exactly one cycle. `dma_len`=`in_len`. Clear the sticky done bits. Go to STREAM.
  - STREAM: `s_tready`=1. Each cycle with `s_tvalid`&&`s_tready` asserts `valid_in` and increments the word counter. `sop`=1 on word 0. `eop`=1 on word `in_len`-1, then go to WAIT.
  - WAIT: `s_tready`=0. Wait until `dma_seen` is set and (`conv_seen` & `ch_mask`)==`ch_mask`, then go to NEXT.
  - NEXT: layer++; `rd_addr` += `in_len`<<2; `wr_addr` += `out_len`<<2. Go to DONE if the new layer == `n_layer`, else go to ISSUE.
  - DONE: `irq_done`=1 for one cycle, then IDLE.
  - ERR: `irq_err`=1 for one cycle, `err_code` set, then IDLE. `err_code` holds until the next accepted `cfg_start`, which clears it to 0.
- Sticky done capture:
  - `dma_seen` and `conv_seen[i]` set on their pulses in any of ISSUE, STREAM or WAIT, so early completion is kept.
  - Pulses from channels outside `ch_mask` are ignored.
  - Pulses arriving in IDLE are ignored.
- Address arithmetic is modulo 2^ADDR_W and wraps silently. The shifts are done at ADDR_W width.
- Watchdog:
  - Counts in STREAM and WAIT.
  - Cleared on entry to ISSUE, on any accepted word, and on any newly set sticky bit.
  - Reaching all-ones goes to ERR with code 2.
- Abort: `cfg_abort` in any state except IDLE/DONE/ERR goes to ERR with code 3 on the next cycle, and has priority over every other transition that cycle. An abort in IDLE is ignored.
- `busy`=1 in every state except IDLE. `cur_layer` shows the latched layer index.

## Timing
- Reset: all outputs are 0 and the state is IDLE; counters, sticky bits and addresses are cleared. Reset acts immediately mid-run, with no pulse generated.
- All outputs are registered, except `s_tready`, `valid_in`, `sop` and `eop`. Those are decoded from state and counter, with `valid_in` = `s_tvalid`&&`s_tready`.
- Latency:
  - `cfg_start` sampled at cycle T: CHECK at T+1, `dma_go`/`conv_start` high at T+2.
  - Bad config: `irq_err` at T+2.
- Layer turnaround: last completion condition at cycle C gives NEXT at C+1, then ISSUE or DONE at C+2.
- `eop` and the completion of WAIT may fall on the same cycle as `dma_done`. Capture must not be lost.
- When `in_len`==1, `sop` and `eop` are both high on the same word.

## Test plan
- Single layer: bases 0x1000/0x8000, `in_len`=4, `ch_mask`=4'b0011, `s_tvalid` held high, `dma_done` and then both channels done. Required: `dma_go` at T+2, 4 `valid_in` words, `sop` on word 0, `eop` on word 3, one `irq_done`, `err_code`=0.
- Three layers, `in_len`=16, `out_len`=8. Required: `dma_rd_addr` = 0x1000, 0x1040, 0x1080; `dma_wr_addr` = 0x8000, 0x8020, 0x8040; `cur_layer` = 0, 1, 2; exactly 3 `dma_go` pulses.
- Early and simultaneous done:
  - `conv_done[1]` before `eop`, and `dma_done` on the same cycle as `eop`. Required: the layer completes with no hang.
  - A done pulse on an unmasked channel has no effect.
- Bad config: `n_layer`=0, then `ch_mask`=0, then `n_layer`=9. Required: `irq_err` at T+2 with `err_code`=1 each time, and no `dma_go`.
- Watchdog with `TO_W`=4: withhold `conv_done`. Required: `irq_err` with `err_code`=2 about 15 cycles after the last progress, and `busy` low the next cycle.
- Abort and reset:
  - `cfg_abort` mid-STREAM. Required: ERR next cycle with `err_code`=3, `s_tready` low.
  - `cfg_start` while busy is ignored.
  - `rst` mid-WAIT forces all outputs to 0 immediately.

Source files
------------

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//
// Purpose:
//   Multi-layer, multi-channel control sequencer for the CNN accelerator.
//   For each of cfg_n_layer layers it computes the DMA read/write addresses,
//   issues one DMA request, starts the masked convolution channels, frames
//   the inbound stream (valid_in/sop/eop) and collects DMA and per-channel
//   completion. A run can be aborted, is guarded by a progress watchdog and
//   reports its outcome through irq_done / irq_err / err_code.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_start/abort     one-cycle control pulses from the CPU registers
//   cfg_n_layer..mask   run configuration, latched on an accepted start
//   dma_go/addr/len     DMA request towards the AXI DMA wrapper
//   dma_done            DMA completion pulse
//   s_tvalid/s_tready   inbound stream handshake
//   conv_start/done     per-channel start and completion pulses
//   valid_in/sop/eop    stream framing towards the convolution array
//   busy, cur_layer     status
//   irq_done, irq_err   run-complete and error pulses
//   err_code            0 none, 1 bad config, 2 timeout, 3 abort
// ---------------------------------------------------------------------------
module layer_sequencer #(
  parameter  int ADDR_W     = 32,
  parameter  int LEN_W      = 16,
  parameter  int N_CH       = 4,
  parameter  int MAX_LAYERS = 8,
  parameter  int TO_W       = 20,
  localparam int LW         = $clog2(MAX_LAYERS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [LW-1:0]     cfg_n_layer,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [LEN_W-1:0]  cfg_in_len,
  input  logic [LEN_W-1:0]  cfg_out_len,
  input  logic [N_CH-1:0]   cfg_ch_mask,
  output logic              dma_go,
  output logic [ADDR_W-1:0] dma_rd_addr,
  output logic [ADDR_W-1:0] dma_wr_addr,
  output logic [LEN_W-1:0]  dma_len,
  input  logic              dma_done,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [N_CH-1:0]   conv_start,
  input  logic [N_CH-1:0]   conv_done,
  output logic              valid_in,
  output logic              sop,
  output logic              eop,
  output logic              busy,
  output logic [LW-1:0]     cur_layer,
  output logic              irq_done,
  output logic              irq_err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_STREAM,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [LW-1:0] MAX_L = LW'(MAX_LAYERS);

  state_t              state;
  logic [LW-1:0]       n_layer_q;
  logic [LEN_W-1:0]    out_len_q;
  logic [N_CH-1:0]     ch_mask_q;
  logic [LEN_W-1:0]    word_cnt;
  logic [TO_W-1:0]     wdog;
  logic                dma_seen;
  logic [N_CH-1:0]     conv_seen;

  logic                capture_en;
  logic [N_CH-1:0]     conv_hit;
  logic                new_bits;
  logic                wait_done;
  logic                abort_hit;
  logic                wdog_max;
  logic [ADDR_W-1:0]   rd_step;
  logic [ADDR_W-1:0]   wr_step;
  logic [LW-1:0]       next_layer;

  // Stream framing is decoded straight from state and word counter so the
  // convolution array sees the word in the same cycle it is accepted.
  // The dma_len register doubles as the latched per-layer input length.
  assign s_tready = (state == S_STREAM);
  assign valid_in = s_tvalid && s_tready;
  assign sop      = valid_in && (word_cnt == '0);
  assign eop      = valid_in && (word_cnt == dma_len - LEN_W'(1));

  // Completion bookkeeping. Pulses from unmasked channels are dropped here,
  // and the current-cycle pulses are folded into the WAIT exit test so a
  // completion arriving on the last cycle is not delayed or lost.
  assign capture_en = (state == S_ISSUE) || (state == S_STREAM) || (state == S_WAIT);
  assign conv_hit   = conv_done & ch_mask_q;
  assign new_bits   = capture_en &&
                      ((dma_done && !dma_seen) || (|(conv_hit & ~conv_seen)));
  assign wait_done  = (dma_seen || dma_done) &&
                      (((conv_seen | conv_hit) & ch_mask_q) == ch_mask_q);

  // Abort only matters while a run is in flight; IDLE/DONE/ERR ignore it.
  assign abort_hit  = cfg_abort &&
                      (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
  assign wdog_max   = &wdog;

  // Per-layer address strides are formed at address width so the byte
  // offset cannot overflow the word count field before the add wraps.
  assign rd_step    = ADDR_W'(dma_len) << 2;
  assign wr_step    = ADDR_W'(out_len_q) << 2;
  assign next_layer = cur_layer + LW'(1);

  // Main sequencer: one registered FSM that also owns every registered
  // output. Pulse outputs default low each cycle and are raised only on the
  // transition into the state where they must be visible. Abort is checked
  // ahead of the state case so it wins over any other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      n_layer_q   <= '0;
      out_len_q   <= '0;
      ch_mask_q   <= '0;
      word_cnt    <= '0;
      wdog        <= '0;
      dma_seen    <= 1'b0;
      conv_seen   <= '0;
      dma_go      <= 1'b0;
      dma_rd_addr <= '0;
      dma_wr_addr <= '0;
      dma_len     <= '0;
      conv_start  <= '0;
      busy        <= 1'b0;
      cur_layer   <= '0;
      irq_done    <= 1'b0;
      irq_err     <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      dma_go     <= 1'b0;
      conv_start <= '0;
      irq_done   <= 1'b0;
      irq_err    <= 1'b0;

      if (capture_en) begin
        dma_seen  <= dma_seen | dma_done;
        conv_seen <= conv_seen | conv_hit;
      end

      if (abort_hit) begin
        state    <= S_ERR;
        err_code <= 2'd3;
        irq_err  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_start) begin
              n_layer_q   <= cfg_n_layer;
              dma_rd_addr <= cfg_rd_base;
              dma_wr_addr <= cfg_wr_base;
              dma_len     <= cfg_in_len;
              out_len_q   <= cfg_out_len;
              ch_mask_q   <= cfg_ch_mask;
              err_code    <= 2'd0;
              busy        <= 1'b1;
              state       <= S_CHECK;
            end
          end

          S_CHECK: begin
            if ((n_layer_q == '0) || (n_layer_q > MAX_L) ||
                (dma_len == '0) || (ch_mask_q == '0)) begin
              err_code <= 2'd1;
              irq_err  <= 1'b1;
              state    <= S_ERR;
            end else begin
              cur_layer  <= '0;
              dma_go     <= 1'b1;
              conv_start <= ch_mask_q;
              dma_seen   <= 1'b0;
              conv_seen  <= '0;
              word_cnt   <= '0;
              wdog       <= '0;
              state      <= S_ISSUE;
            end
          end

          S_ISSUE: begin
            state <= S_STREAM;
          end

          S_STREAM: begin
            if (valid_in) begin
              wdog     <= '0;
              word_cnt <= word_cnt + LEN_W'(1);
              if (eop) begin
                state <= S_WAIT;
              end
            end else if (new_bits) begin
              wdog <= '0;
            end else if (wdog_max) begin
              err_code <= 2'd2;
              irq_err  <= 1'b1;
              state    <= S_ERR;
            end else begin
              wdog <= wdog + TO_W'(1);
            end
          end

          S_WAIT: begin
            if (wait_done) begin
              state <= S_NEXT;
            end else if (new_bits) begin
              wdog <= '0;
            end else if (wdog_max) begin
              err_code <= 2'd2;
              irq_err  <= 1'b1;
              state    <= S_ERR;
            end else begin
              wdog <= wdog + TO_W'(1);
            end
          end

          S_NEXT: begin
            cur_layer   <= next_layer;
            dma_rd_addr <= dma_rd_addr + rd_step;
            dma_wr_addr <= dma_wr_addr + wr_step;
            if (next_layer == n_layer_q) begin
              irq_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              dma_go     <= 1'b1;
              conv_start <= ch_mask_q;
              dma_seen   <= 1'b0;
              conv_seen  <= '0;
              word_cnt   <= '0;
              wdog       <= '0;
              state      <= S_ISSUE;
            end
          end

          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          S_ERR: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_layer_sequencer
//
// Directed bench for layer_sequencer. Expected DMA requests and end-of-run
// interrupts are queued when a run is started and checked by a monitor as
// the DUT produces them. A responder process plays the DMA wrapper and the
// convolution channels in one of several completion patterns.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 16;
  localparam int N_CH       = 4;
  localparam int MAX_LAYERS = 8;
  localparam int TO_W       = 4;
  localparam int LW         = 4;

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic              cfg_abort;
  logic [LW-1:0]     cfg_n_layer;
  logic [ADDR_W-1:0] cfg_rd_base;
  logic [ADDR_W-1:0] cfg_wr_base;
  logic [LEN_W-1:0]  cfg_in_len;
  logic [LEN_W-1:0]  cfg_out_len;
  logic [N_CH-1:0]   cfg_ch_mask;
  logic              dma_go;
  logic [ADDR_W-1:0] dma_rd_addr;
  logic [ADDR_W-1:0] dma_wr_addr;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_done;
  logic              s_tvalid;
  logic              s_tready;
  logic [N_CH-1:0]   conv_start;
  logic [N_CH-1:0]   conv_done;
  logic              valid_in;
  logic              sop;
  logic              eop;
  logic              busy;
  logic [LW-1:0]     cur_layer;
  logic              irq_done;
  logic              irq_err;
  logic [1:0]        err_code;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] wr;
    logic [15:0] len;
    logic [3:0]  layer;
    logic [3:0]  mask;
  } dma_exp_t;

  dma_exp_t    exp_dma[$];
  int          exp_irq[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          dma_go_cnt = 0;
  int          word_total = 0;
  int          irq_done_cnt = 0;
  int          word_idx = 0;
  int          base_go, base_words, base_dones;
  int          last_prog = 0;
  int          err_cyc = 0;
  int          resp_mode = 3;
  logic [15:0] exp_len = 16'd1;
  logic [3:0]  resp_mask = 4'd0;

  layer_sequencer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .N_CH(N_CH),
    .MAX_LAYERS(MAX_LAYERS), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_n_layer(cfg_n_layer), .cfg_rd_base(cfg_rd_base),
    .cfg_wr_base(cfg_wr_base), .cfg_in_len(cfg_in_len),
    .cfg_out_len(cfg_out_len), .cfg_ch_mask(cfg_ch_mask),
    .dma_go(dma_go), .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_len(dma_len), .dma_done(dma_done),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .conv_start(conv_start), .conv_done(conv_done),
    .valid_in(valid_in), .sop(sop), .eop(eop),
    .busy(busy), .cur_layer(cur_layer),
    .irq_done(irq_done), .irq_err(irq_err), .err_code(err_code)
  );

  // 100 MHz clock and a free-running cycle counter for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] all_outs();
    return 128'({dma_go, dma_rd_addr, dma_wr_addr, dma_len, s_tready, conv_start,
                 valid_in, sop, eop, busy, cur_layer, irq_done, irq_err, err_code});
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected DMA requests and end interrupt, then pulse start and
  // check the fixed start latency (busy at T+1, go or error at T+2).
  task automatic applyStimulus(input logic [3:0] n, input logic [31:0] rd,
                               input logic [31:0] wr, input logic [15:0] il,
                               input logic [15:0] ol, input logic [3:0] mask,
                               input int end_code);
    bit       good;
    dma_exp_t e;
    good = (n != 0) && (n <= 4'd8) && (il != 0) && (mask != 0);
    if (good) begin
      for (int k = 0; k < int'(n); k++) begin
        e.rd    = rd + 32'(k) * 32'(il) * 32'd4;
        e.wr    = wr + 32'(k) * 32'(ol) * 32'd4;
        e.len   = il;
        e.layer = 4'(k);
        e.mask  = mask;
        exp_dma.push_back(e);
      end
    end
    if (end_code >= 0) exp_irq.push_back(end_code);
    exp_len   = il;
    resp_mask = mask;
    @(negedge clk);
    cfg_n_layer = n;
    cfg_rd_base = rd;
    cfg_wr_base = wr;
    cfg_in_len  = il;
    cfg_out_len = ol;
    cfg_ch_mask = mask;
    cfg_start   = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    checkOutput("start_busy_T1", 128'(busy), 128'(1));
    checkOutput("start_no_go_T1", 128'(dma_go), 128'(0));
    @(posedge clk); #1;
    if (good) begin
      checkOutput("dma_go_T2", 128'(dma_go), 128'(1));
    end else begin
      checkOutput("bad_cfg_irq_err_T2", 128'(irq_err), 128'(1));
      checkOutput("bad_cfg_err_code", 128'(err_code), 128'(1));
      checkOutput("bad_cfg_no_go", 128'(dma_go), 128'(0));
    end
  endtask

  task automatic waitIdle(input int bound);
    int i;
    i = 0;
    while (busy && i < bound) begin
      @(posedge clk); #1;
      i++;
    end
    checkOutput("idle_reached", 128'(busy), 128'(0));
  endtask

  task automatic markStart();
    base_go    = dma_go_cnt;
    base_words = word_total;
    base_dones = irq_done_cnt;
  endtask

  task automatic endCheck(input string tag, input int go, input int words,
                          input int dones);
    checkOutput({tag, "_go_count"}, 128'(dma_go_cnt - base_go), 128'(go));
    checkOutput({tag, "_words"}, 128'(word_total - base_words), 128'(words));
    checkOutput({tag, "_irq_done"}, 128'(irq_done_cnt - base_dones), 128'(dones));
    checkOutput({tag, "_dma_q_empty"}, 128'(exp_dma.size()), 128'(0));
    checkOutput({tag, "_irq_q_empty"}, 128'(exp_irq.size()), 128'(0));
  endtask

  // Monitor: compares every DMA request and interrupt against the queues
  // and checks stream framing word by word.
  always @(negedge clk) begin : monitor
    dma_exp_t e;
    int       code;
    if (!rst) begin
      if (dma_go) begin
        dma_go_cnt++;
        word_idx = 0;
        checkOutput("dma_go_expected", 128'(exp_dma.size() != 0), 128'(1));
        if (exp_dma.size() != 0) begin
          e = exp_dma.pop_front();
          checkOutput("dma_rd_addr", 128'(dma_rd_addr), 128'(e.rd));
          checkOutput("dma_wr_addr", 128'(dma_wr_addr), 128'(e.wr));
          checkOutput("dma_len", 128'(dma_len), 128'(e.len));
          checkOutput("cur_layer", 128'(cur_layer), 128'(e.layer));
          checkOutput("conv_start", 128'(conv_start), 128'(e.mask));
        end
      end
      if (valid_in) begin
        checkOutput("sop", 128'(sop), 128'(word_idx == 0));
        checkOutput("eop", 128'(eop), 128'(word_idx == int'(exp_len) - 1));
        word_idx++;
        word_total++;
      end else begin
        checkOutput("framing_idle", 128'({sop, eop}), 128'(0));
      end
      if (irq_done) irq_done_cnt++;
      if (irq_done || irq_err) begin
        checkOutput("irq_expected", 128'(exp_irq.size() != 0), 128'(1));
        if (exp_irq.size() != 0) begin
          code = exp_irq.pop_front();
          checkOutput("irq_kind", 128'({irq_done, irq_err}),
                      128'((code == 0) ? 2'b10 : 2'b01));
          checkOutput("irq_err_code", 128'(err_code), 128'(code));
        end
      end
    end
  end

  // Responder: plays DMA wrapper and channels.
  //   0: dma_done then all masked channels, after eop
  //   1: conv_done[1] (+ unmasked ch2) at sop, dma_done on the eop cycle
  //   2: dma_done plus every channel except ch3, then silence
  //   3: never responds
  initial begin : responder
    dma_done  = 1'b0;
    conv_done = '0;
    forever begin
      @(negedge clk);
      if (!rst && resp_mode == 0 && eop) begin
        @(negedge clk); dma_done = 1'b1;
        @(negedge clk); dma_done = 1'b0; conv_done = resp_mask;
        @(negedge clk); conv_done = '0;
      end else if (!rst && resp_mode == 1 && sop) begin
        conv_done = 4'b0110;
        @(negedge clk); conv_done = '0;
      end else if (!rst && resp_mode == 1 && eop) begin
        dma_done = 1'b1;
        @(negedge clk); dma_done = 1'b0; conv_done = 4'b0001;
        @(negedge clk); conv_done = '0;
      end else if (!rst && resp_mode == 2 && eop) begin
        @(negedge clk); dma_done = 1'b1; conv_done = 4'b0111; last_prog = cyc;
        @(negedge clk); dma_done = 1'b0; conv_done = '0;
      end
    end
  end

  initial begin : global_timeout
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : stimulus
    int i;
    rst = 1'b1;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_n_layer = '0; cfg_rd_base = '0; cfg_wr_base = '0;
    cfg_in_len = '0; cfg_out_len = '0; cfg_ch_mask = '0;
    s_tvalid = 1'b1;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", all_outs(), 128'(0));
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_outputs", all_outs(), 128'(0));

    $display("[TB] single layer");
    resp_mode = 0;
    markStart();
    applyStimulus(4'd1, 32'h1000, 32'h8000, 16'd4, 16'd4, 4'b0011, 0);
    waitIdle(100);
    checkOutput("single_err_code", 128'(err_code), 128'(0));
    endCheck("single", 1, 4, 1);

    $display("[TB] three layers, start while busy");
    markStart();
    applyStimulus(4'd3, 32'h1000, 32'h8000, 16'd16, 16'd8, 4'b1111, 0);
    repeat (5) @(posedge clk);
    #1;
    cfg_n_layer = 4'd1; cfg_rd_base = 32'hDEAD_0000; cfg_in_len = 16'd3;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    checkOutput("start_ignored_busy", 128'(busy), 128'(1));
    waitIdle(300);
    endCheck("three", 3, 48, 1);

    $display("[TB] max layers, in_len 1, address wrap");
    markStart();
    applyStimulus(4'd8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd1, 16'd2, 4'b0100, 0);
    waitIdle(200);
    endCheck("maxl", 8, 8, 1);

    $display("[TB] bad configs");
    markStart();
    applyStimulus(4'd0, 32'h1000, 32'h8000, 16'd4, 16'd4, 4'b0011, 1);
    waitIdle(10);
    applyStimulus(4'd2, 32'h1000, 32'h8000, 16'd4, 16'd4, 4'b0000, 1);
    waitIdle(10);
    applyStimulus(4'd9, 32'h1000, 32'h8000, 16'd4, 16'd4, 4'b0011, 1);
    waitIdle(10);
    applyStimulus(4'd1, 32'h1000, 32'h8000, 16'd0, 16'd4, 4'b0011, 1);
    waitIdle(10);
    endCheck("badcfg", 0, 0, 0);

    $display("[TB] early and simultaneous completion");
    resp_mode = 1;
    markStart();
    applyStimulus(4'd2, 32'h2000, 32'h9000, 16'd4, 16'd4, 4'b0011, 0);
    waitIdle(100);
    checkOutput("early_err_code_cleared", 128'(err_code), 128'(0));
    endCheck("early", 2, 8, 1);

    $display("[TB] watchdog");
    resp_mode = 2;
    markStart();
    applyStimulus(4'd1, 32'h3000, 32'hA000, 16'd4, 16'd4, 4'b1001, 2);
    i = 0;
    while (!irq_err && i < 80) begin
      @(posedge clk); #1;
      i++;
    end
    err_cyc = cyc;
    checkOutput("wdog_fired", 128'(irq_err), 128'(1));
    checkOutput("wdog_err_code", 128'(err_code), 128'(2));
    checkOutput("wdog_latency_window",
                128'((err_cyc - last_prog >= 14) && (err_cyc - last_prog <= 20)), 128'(1));
    @(posedge clk); #1;
    checkOutput("wdog_busy_low", 128'(busy), 128'(0));
    endCheck("wdog", 1, 4, 0);

    $display("[TB] abort mid-stream");
    resp_mode = 3;
    markStart();
    applyStimulus(4'd1, 32'h4000, 32'hB000, 16'd16, 16'd16, 4'b0001, 3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_in_stream", 128'(s_tready), 128'(1));
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    checkOutput("abort_irq_err", 128'(irq_err), 128'(1));
    checkOutput("abort_err_code", 128'(err_code), 128'(3));
    checkOutput("abort_tready_low", 128'(s_tready), 128'(0));
    waitIdle(10);
    endCheck("abort", 1, 3, 0);
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_abort_ignored", 128'({busy, irq_err}), 128'(0));

    $display("[TB] reset mid-wait");
    markStart();
    applyStimulus(4'd1, 32'h5000, 32'hC000, 16'd4, 16'd4, 4'b0011, -1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("in_wait", 128'({busy, s_tready}), 128'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_wait", all_outs(), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("after_reset_idle", all_outs(), 128'(0));
    endCheck("rstwait", 1, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
